// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C line front-end.
package i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BITS     = 2'd1,
    ST_ACK_SLOT = 2'd2
  } i2c_state_e;

  localparam int unsigned I2C_BITS_PER_BYTE = 8;
  localparam logic        I2C_LINE_IDLE     = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser followed by a persistence filter stepped by a sample tick.
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int unsigned FILTER_WIDTH = 3
) (
  input  logic FAST_CLOCK,
  input  logic RESET_N,
  input  logic SAMPLE_TICK,
  input  logic LINE_RAW,
  output logic LINE_FILT
);

  logic [1:0]              sync_r;
  logic [FILTER_WIDTH-1:0] shift_r;
  logic [FILTER_WIDTH-1:0] window_s;
  logic                    filt_r;

  // Sample window including the bit about to be shifted in.
  always_comb begin
    window_s = {shift_r[FILTER_WIDTH-2:0], sync_r[1]};
  end

  // Synchronise, shift on tick, and move the output only on a unanimous window.
  always_ff @(posedge FAST_CLOCK) begin
    if (!RESET_N) begin
      sync_r  <= {2{I2C_LINE_IDLE}};
      shift_r <= {FILTER_WIDTH{I2C_LINE_IDLE}};
      filt_r  <= I2C_LINE_IDLE;
    end else begin
      sync_r <= {sync_r[0], LINE_RAW};
      if (SAMPLE_TICK) begin
        shift_r <= window_s;
        if (window_s == {FILTER_WIDTH{1'b0}}) begin
          filt_r <= 1'b0;
        end else if (window_s == {FILTER_WIDTH{1'b1}}) begin
          filt_r <= 1'b1;
        end else begin
          filt_r <= filt_r;
        end
      end else begin
        shift_r <= shift_r;
        filt_r  <= filt_r;
      end
    end
  end

  assign LINE_FILT = filt_r;

endmodule

// File: rtl/i2c_bus_monitor.sv
// Filters SCL/SDA, detects START/STOP, tracks bus-busy and deserialises bytes and ACKs.
module i2c_bus_monitor
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned FILTER_WIDTH = 3,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic       FAST_CLOCK,
  input  logic       RESET_N,
  input  logic       SCL_IN,
  input  logic       SDA_IN,
  output logic       SCL_FILT,
  output logic       SDA_FILT,
  output logic       START_DET,
  output logic       REP_START,
  output logic       STOP_DET,
  output logic       BUS_BUSY,
  output logic [7:0] RX_BYTE,
  output logic       BYTE_VALID,
  output logic       ACK_BIT,
  output logic       ACK_VALID,
  output logic       TIMEOUT
);

  localparam int unsigned     PRE_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned     TMO_W    = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IDLE_TIMEOUT - 1);
  localparam logic [3:0]       BIT_LAST = 4'(I2C_BITS_PER_BYTE - 1);

  logic [PRE_W-1:0] pre_cnt_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             tick_s, scl_filt_s, sda_filt_s, scl_q_r, sda_q_r;
  logic             scl_rise_s, start_s, stop_s, lines_idle_s, tmo_hit_s;
  i2c_state_e       state_r;
  logic [3:0]       bit_cnt_r;
  logic [6:0]       shreg_r;
  logic [7:0]       rx_byte_r;
  logic             start_det_r, rep_start_r, stop_det_r, busy_r;
  logic             byte_valid_r, ack_bit_r, ack_valid_r, timeout_r;

  i2c_line_filter #(.FILTER_WIDTH(FILTER_WIDTH)) u_scl_filter (
    .FAST_CLOCK(FAST_CLOCK), .RESET_N(RESET_N), .SAMPLE_TICK(tick_s),
    .LINE_RAW(SCL_IN), .LINE_FILT(scl_filt_s)
  );

  i2c_line_filter #(.FILTER_WIDTH(FILTER_WIDTH)) u_sda_filter (
    .FAST_CLOCK(FAST_CLOCK), .RESET_N(RESET_N), .SAMPLE_TICK(tick_s),
    .LINE_RAW(SDA_IN), .LINE_FILT(sda_filt_s)
  );

  // Conditions need SCL high on both sides, so simultaneous SCL/SDA moves never qualify.
  always_comb begin
    tick_s       = (pre_cnt_r == PRE_LAST);
    scl_rise_s   = !scl_q_r && scl_filt_s;
    start_s      = scl_q_r && scl_filt_s && sda_q_r && !sda_filt_s;
    stop_s       = scl_q_r && scl_filt_s && !sda_q_r && sda_filt_s;
    lines_idle_s = busy_r && scl_filt_s && sda_filt_s;
    tmo_hit_s    = lines_idle_s && tick_s && (tmo_cnt_r == TMO_LAST);
  end

  // Sample-tick prescaler and previous-cycle copies of the filtered lines.
  always_ff @(posedge FAST_CLOCK) begin
    if (!RESET_N) begin
      pre_cnt_r <= {PRE_W{1'b0}};
      scl_q_r   <= I2C_LINE_IDLE;
      sda_q_r   <= I2C_LINE_IDLE;
    end else begin
      pre_cnt_r <= tick_s ? {PRE_W{1'b0}} : pre_cnt_r + {{(PRE_W-1){1'b0}}, 1'b1};
      scl_q_r   <= scl_filt_s;
      sda_q_r   <= sda_filt_s;
    end
  end

  // Idle-bus timeout counter: counts ticks of both lines high while busy.
  always_ff @(posedge FAST_CLOCK) begin
    if (!RESET_N) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (!lines_idle_s || tmo_hit_s) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (tick_s) begin
      tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Bus FSM; STOP outranks the timeout when both land in one cycle.
  always_ff @(posedge FAST_CLOCK) begin
    if (!RESET_N) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 4'd0;
      shreg_r      <= 7'd0;
      rx_byte_r    <= 8'd0;
      start_det_r  <= 1'b0;
      rep_start_r  <= 1'b0;
      stop_det_r   <= 1'b0;
      busy_r       <= 1'b0;
      byte_valid_r <= 1'b0;
      ack_bit_r    <= 1'b0;
      ack_valid_r  <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      start_det_r  <= 1'b0;
      stop_det_r   <= 1'b0;
      byte_valid_r <= 1'b0;
      ack_valid_r  <= 1'b0;
      timeout_r    <= 1'b0;
      if (start_s) begin
        start_det_r <= 1'b1;
        rep_start_r <= busy_r;
        busy_r      <= 1'b1;
        bit_cnt_r   <= 4'd0;
        state_r     <= ST_BITS;
      end else if (stop_s) begin
        stop_det_r <= 1'b1;
        busy_r     <= 1'b0;
        bit_cnt_r  <= 4'd0;
        state_r    <= ST_IDLE;
      end else if (tmo_hit_s) begin
        timeout_r <= 1'b1;
        busy_r    <= 1'b0;
        bit_cnt_r <= 4'd0;
        state_r   <= ST_IDLE;
      end else if (scl_rise_s) begin
        case (state_r)
          ST_BITS: begin
            shreg_r <= {shreg_r[5:0], sda_filt_s};
            if (bit_cnt_r == BIT_LAST) begin
              rx_byte_r    <= {shreg_r, sda_filt_s};
              byte_valid_r <= 1'b1;
              bit_cnt_r    <= 4'd0;
              state_r      <= ST_ACK_SLOT;
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end
          ST_ACK_SLOT: begin
            ack_bit_r   <= ~sda_filt_s;
            ack_valid_r <= 1'b1;
            state_r     <= ST_BITS;
          end
          ST_IDLE: state_r <= ST_IDLE;
          default: state_r <= ST_IDLE;
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign SCL_FILT   = scl_filt_s;
  assign SDA_FILT   = sda_filt_s;
  assign START_DET  = start_det_r;
  assign REP_START  = rep_start_r;
  assign STOP_DET   = stop_det_r;
  assign BUS_BUSY   = busy_r;
  assign RX_BYTE    = rx_byte_r;
  assign BYTE_VALID = byte_valid_r;
  assign ACK_BIT    = ack_bit_r;
  assign ACK_VALID  = ack_valid_r;
  assign TIMEOUT    = timeout_r;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Self-checking bench: directed vector table, hand-written corner sequences, random transactions.
module tb_i2c_bus_monitor;

  localparam int CLK_DIV      = 4;
  localparam int FILTER_WIDTH = 3;
  localparam int IDLE_TIMEOUT = 16;

  logic       FAST_CLOCK = 1'b0;
  logic       RESET_N    = 1'b0;
  logic       SCL_IN     = 1'b1;
  logic       SDA_IN     = 1'b1;
  logic       SCL_FILT, SDA_FILT, START_DET, REP_START, STOP_DET, BUS_BUSY;
  logic [7:0] RX_BYTE;
  logic       BYTE_VALID, ACK_BIT, ACK_VALID, TIMEOUT;

  i2c_bus_monitor #(
    .CLK_DIV(CLK_DIV), .FILTER_WIDTH(FILTER_WIDTH), .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .FAST_CLOCK(FAST_CLOCK), .RESET_N(RESET_N), .SCL_IN(SCL_IN), .SDA_IN(SDA_IN),
    .SCL_FILT(SCL_FILT), .SDA_FILT(SDA_FILT), .START_DET(START_DET), .REP_START(REP_START),
    .STOP_DET(STOP_DET), .BUS_BUSY(BUS_BUSY), .RX_BYTE(RX_BYTE), .BYTE_VALID(BYTE_VALID),
    .ACK_BIT(ACK_BIT), .ACK_VALID(ACK_VALID), .TIMEOUT(TIMEOUT)
  );

  always #5 FAST_CLOCK = ~FAST_CLOCK;

  typedef struct {
    bit         lead_rep;
    logic [7:0] data;
    bit         ack_low;
    int         partial;
    bit         do_stop;
    logic       exp_rep;
    bit         exp_has_byte;
    logic [7:0] exp_byte;
    logic       exp_ack;
    bit         exp_stop;
  } vec_t;

  int         n_checks = 0;
  int         n_errors = 0;
  int         half_p   = 32;
  bit         model_busy = 1'b0;
  logic [7:0] got_byte_q[$];
  logic       got_ack_q[$];
  logic       got_rep_q[$];
  int         stop_cnt = 0;
  int         tmo_cnt  = 0;

  // Observed pulses, sampled on the inactive edge.
  always @(negedge FAST_CLOCK) begin
    if (START_DET)  got_rep_q.push_back(REP_START);
    if (BYTE_VALID) got_byte_q.push_back(RX_BYTE);
    if (ACK_VALID)  got_ack_q.push_back(ACK_BIT);
    if (STOP_DET)   stop_cnt++;
    if (TIMEOUT)    tmo_cnt++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge FAST_CLOCK);
  endtask

  task automatic clear_obs();
    got_byte_q.delete();
    got_ack_q.delete();
    got_rep_q.delete();
    stop_cnt = 0;
    tmo_cnt  = 0;
  endtask

  task automatic i2c_start();
    SDA_IN = 1'b0;
    cyc(half_p);
    SCL_IN = 1'b0;
  endtask

  task automatic i2c_rep_start();
    cyc(half_p / 2);
    SDA_IN = 1'b1;
    cyc(half_p - half_p / 2);
    SCL_IN = 1'b1;
    cyc(half_p);
    SDA_IN = 1'b0;
    cyc(half_p);
    SCL_IN = 1'b0;
  endtask

  task automatic i2c_stop();
    cyc(half_p / 2);
    SDA_IN = 1'b0;
    cyc(half_p - half_p / 2);
    SCL_IN = 1'b1;
    cyc(half_p);
    SDA_IN = 1'b1;
    cyc(half_p);
  endtask

  // One bit; g>0 adds a g-cycle inverted SDA glitch mid SCL-high.
  task automatic i2c_bit(input logic b, input int g);
    cyc(half_p / 2);
    SDA_IN = b;
    cyc(half_p - half_p / 2);
    SCL_IN = 1'b1;
    if (g > 0) begin
      cyc(half_p / 2);
      SDA_IN = ~b;
      cyc(g);
      SDA_IN = b;
      cyc(half_p - half_p / 2 - g);
    end else begin
      cyc(half_p);
    end
    SCL_IN = 1'b0;
  endtask

  task automatic drive_txn(input bit lead_rep, input logic [7:0] data, input bit ack_low,
                           input int partial, input bit do_stop, input bit glitch);
    if (lead_rep) i2c_rep_start();
    else          i2c_start();
    chk("busy_after_start", BUS_BUSY, 1);
    if (partial == 0) begin
      for (int i = 7; i >= 0; i--) i2c_bit(data[i], glitch ? $urandom_range(1, 6) : 0);
      i2c_bit(~ack_low, glitch ? $urandom_range(1, 6) : 0);
    end else begin
      for (int i = 0; i < partial; i++) i2c_bit(data[7-i], glitch ? $urandom_range(1, 6) : 0);
    end
    if (do_stop) i2c_stop();
  endtask

  task automatic check_txn(input logic exp_rep, input bit has_byte, input logic [7:0] exp_byte,
                           input logic exp_ack, input bit exp_stop);
    chk("start_count", got_rep_q.size(), 1);
    if (got_rep_q.size() > 0) chk("rep_start", got_rep_q[0], exp_rep);
    chk("byte_count", got_byte_q.size(), has_byte ? 1 : 0);
    if (has_byte && got_byte_q.size() > 0) chk("rx_byte", got_byte_q[0], exp_byte);
    chk("ack_count", got_ack_q.size(), has_byte ? 1 : 0);
    if (has_byte && got_ack_q.size() > 0) chk("ack_bit", got_ack_q[0], exp_ack);
    chk("stop_count", stop_cnt, exp_stop ? 1 : 0);
    chk("busy_after_txn", BUS_BUSY, exp_stop ? 0 : 1);
    chk("timeout_count", tmo_cnt, 0);
    clear_obs();
  endtask

  vec_t       vecs[5];
  int         bad, waited, partial;
  logic [7:0] rdata;
  logic       rack, rstop, rglitch;

  initial begin
    vecs[0] = '{1'b0, 8'hA5, 1'b1, 0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 8'h3C, 1'b0, 0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h5A, 1'b1, 0, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 8'hF0, 1'b1, 4, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 8'h81, 1'b1, 0, 1'b1, 1'b0, 1'b1, 8'h81, 1'b1, 1'b1};

    // Reset state.
    cyc(5);
    chk("rst_scl_filt", SCL_FILT, 1);
    chk("rst_sda_filt", SDA_FILT, 1);
    chk("rst_busy", BUS_BUSY, 0);
    chk("rst_rx_byte", RX_BYTE, 0);
    chk("rst_ack_bit", ACK_BIT, 0);
    RESET_N = 1'b1;

    // Idle lines for 200 cycles.
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(1);
      if (!SCL_FILT || !SDA_FILT || BUS_BUSY) bad++;
    end
    chk("idle_lines_busy", bad, 0);
    chk("idle_pulses", got_rep_q.size() + got_byte_q.size() + got_ack_q.size() + stop_cnt + tmo_cnt, 0);

    // 8-cycle SDA glitch while SCL high.
    SDA_IN = 1'b0;
    cyc(8);
    SDA_IN = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (!SDA_FILT) bad++;
    end
    chk("glitch_sda_filt", bad, 0);
    chk("glitch_start", got_rep_q.size(), 0);

    // Directed vector table.
    for (int v = 0; v < 5; v++) begin
      drive_txn(vecs[v].lead_rep, vecs[v].data, vecs[v].ack_low, vecs[v].partial,
                vecs[v].do_stop, 1'b0);
      check_txn(vecs[v].exp_rep, vecs[v].exp_has_byte, vecs[v].exp_byte, vecs[v].exp_ack,
                vecs[v].exp_stop);
    end

    // Random transactions against a transaction-level bus model.
    model_busy = 1'b0;
    for (int t = 0; t < 24; t++) begin
      half_p  = 2 * $urandom_range(12, 20);
      rdata   = 8'($urandom);
      rack    = 1'($urandom_range(0, 1));
      partial = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : 0;
      rstop   = (partial != 0) || ($urandom_range(0, 2) == 0);
      rglitch = 1'($urandom_range(0, 1));
      drive_txn(model_busy, rdata, rack, partial, rstop, rglitch);
      check_txn(model_busy, partial == 0, rdata, rack, rstop);
      model_busy = !rstop;
    end
    half_p = 32;
    if (model_busy) begin
      i2c_stop();
      chk("final_stop", stop_cnt, 1);
      clear_obs();
      model_busy = 1'b0;
    end

    // Both lines high while busy with no STOP -> timeout.
    i2c_start();
    cyc(16);
    SDA_IN = 1'b1;
    cyc(16);
    SCL_IN = 1'b1;
    waited = 0;
    while (tmo_cnt == 0 && waited < 200) begin
      cyc(1);
      waited++;
    end
    chk("timeout_pulse", tmo_cnt, 1);
    chk("timeout_latency_window", (waited >= 60 && waited <= 95) ? 1 : 0, 1);
    chk("timeout_busy", BUS_BUSY, 0);
    cyc(100);
    chk("timeout_once", tmo_cnt, 1);
    chk("timeout_no_stop", stop_cnt, 0);
    chk("timeout_start_rep", (got_rep_q.size() == 1) ? got_rep_q[0] : 1'bx, 0);
    clear_obs();

    // Reset mid-byte after a full byte with ACK.
    drive_txn(1'b0, 8'hC3, 1'b1, 0, 1'b0, 1'b0);
    check_txn(1'b0, 1'b1, 8'hC3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) i2c_bit(1'b0, 0);
    RESET_N = 1'b0;
    cyc(1);
    chk("mid_rst_scl_filt", SCL_FILT, 1);
    chk("mid_rst_sda_filt", SDA_FILT, 1);
    chk("mid_rst_busy", BUS_BUSY, 0);
    chk("mid_rst_rep_start", REP_START, 0);
    chk("mid_rst_rx_byte", RX_BYTE, 0);
    chk("mid_rst_ack_bit", ACK_BIT, 0);
    chk("mid_rst_pulses", {27'd0, START_DET, STOP_DET, BYTE_VALID, ACK_VALID, TIMEOUT}, 0);
    SCL_IN = 1'b1;
    SDA_IN = 1'b1;
    cyc(10);
    RESET_N = 1'b1;
    cyc(60);
    chk("post_rst_busy", BUS_BUSY, 0);
    chk("post_rst_pulses", got_rep_q.size() + got_byte_q.size() + got_ack_q.size() + stop_cnt + tmo_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
